// File: rtl/axis_ad5791_cfg_seq.sv
// axis_ad5791_cfg_seq
// Sequences control-register writes to a bank of AD5791 DACs through a shared
// SPI serializer. For each axis selected in axis_mask the word is presented on
// the config stream for one serializer phase, a send is requested, the
// serializer's busy/idle handshake is followed (with a timeout on the busy
// edge), and send is released for one phase before moving to the next axis.
//
// Optional feature: define AD5791_CFG_SOFTRESET_EN to precede every
// ctrl_word write with a software-reset write (0x400004) to the same axis.
module axis_ad5791_cfg_seq #(
    parameter int NUM_DAC           = 6,
    parameter int DAC_WORD_WIDTH    = 24,
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic                         start,
    input  logic [DAC_WORD_WIDTH-1:0]    ctrl_word,
    input  logic [NUM_DAC-1:0]           axis_mask,
    input  logic                         dac_ready,
    output logic                         configuration_mode,
    output logic [2:0]                   configuration_axis,
    output logic                         configuration_send,
    output logic [SAXIS_TDATA_WIDTH-1:0] M_AXISCFG_tdata,
    output logic                         M_AXISCFG_tvalid,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_DAC-1:0]           skipped
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_LOW, S_WAIT_HIGH, S_RELEASE, S_NEXT, S_EXIT
    } state_t;

    state_t                    state;
    logic [NUM_DAC-1:0]        mask_q;
    logic [DAC_WORD_WIDTH-1:0] word_q;
    logic [2:0]                ptr;
    logic [2:0]                phase_cnt;
    logic [TMO_W-1:0]          tmo_cnt;

    // {found, index} of the lowest set bit of m at or above position lo.
    function automatic logic [3:0] next_axis(input logic [NUM_DAC-1:0] m, input int lo);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_DAC - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0]                first_hit;
    logic [3:0]                later_hit;
    logic [DAC_WORD_WIDTH-1:0] first_word;
    logic                      next_load;
    logic [2:0]                next_ptr;
    logic [DAC_WORD_WIDTH-1:0] next_word;

    assign first_hit = next_axis(axis_mask, 0);
    assign later_hit = next_axis(mask_q, int'(ptr) + 1);

`ifdef AD5791_CFG_SOFTRESET_EN
    localparam logic [DAC_WORD_WIDTH-1:0] SOFT_RESET_WORD = DAC_WORD_WIDTH'(24'h400004);

    // High while the pass in flight is the software-reset write of the axis.
    logic reset_pass;

    assign first_word = SOFT_RESET_WORD;

    // After a soft-reset pass the same axis gets ctrl_word; otherwise move on.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        next_load = later_hit[3];
        next_ptr  = later_hit[2:0];
        next_word = SOFT_RESET_WORD;
        if (reset_pass) begin
            next_load = 1'b1;
            next_ptr  = ptr;
            next_word = word_q;
        end
    end
`else
    assign first_word = ctrl_word;
    assign next_load  = later_hit[3];
    assign next_ptr   = later_hit[2:0];
    assign next_word  = word_q;
`endif

    // Sequencer FSM; every output is a register set on state entry.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state              <= S_IDLE;
            mask_q             <= '0;
            word_q             <= '0;
            ptr                <= '0;
            phase_cnt          <= '0;
            tmo_cnt            <= '0;
            configuration_mode <= 1'b0;
            configuration_axis <= '0;
            configuration_send <= 1'b0;
            M_AXISCFG_tdata    <= '0;
            M_AXISCFG_tvalid   <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            skipped            <= '0;
`ifdef AD5791_CFG_SOFTRESET_EN
            reset_pass         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (axis_mask == '0) begin
                            done <= 1'b1;
                        end else begin
                            mask_q             <= axis_mask;
                            word_q             <= ctrl_word;
                            skipped            <= '0;
                            busy               <= 1'b1;
                            configuration_mode <= 1'b1;
                            ptr                <= first_hit[2:0];
                            configuration_axis <= first_hit[2:0];
                            M_AXISCFG_tdata    <= SAXIS_TDATA_WIDTH'(first_word);
                            M_AXISCFG_tvalid   <= 1'b1;
                            phase_cnt          <= '0;
                            state              <= S_LOAD;
`ifdef AD5791_CFG_SOFTRESET_EN
                            reset_pass         <= 1'b1;
`endif
                        end
                    end
                end
                S_LOAD: begin
                    phase_cnt <= phase_cnt + 3'd1;
                    if (phase_cnt == 3'd7) begin
                        configuration_send <= 1'b1;
                        state              <= S_SEND;
                    end
                end
                S_SEND: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!dac_ready) begin
                        state <= S_WAIT_HIGH;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
                        skipped[ptr]       <= 1'b1;
                        configuration_send <= 1'b0;
                        M_AXISCFG_tvalid   <= 1'b0;
                        phase_cnt          <= '0;
                        state              <= S_RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (dac_ready) begin
                        configuration_send <= 1'b0;
                        M_AXISCFG_tvalid   <= 1'b0;
                        phase_cnt          <= '0;
                        state              <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    phase_cnt <= phase_cnt + 3'd1;
                    if (phase_cnt == 3'd7) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (next_load) begin
                        ptr                <= next_ptr;
                        configuration_axis <= next_ptr;
                        M_AXISCFG_tdata    <= SAXIS_TDATA_WIDTH'(next_word);
                        M_AXISCFG_tvalid   <= 1'b1;
                        phase_cnt          <= '0;
                        state              <= S_LOAD;
`ifdef AD5791_CFG_SOFTRESET_EN
                        reset_pass         <= ~reset_pass;
`endif
                    end else begin
                        configuration_mode <= 1'b0;
                        busy               <= 1'b0;
                        done               <= 1'b1;
                        state              <= S_EXIT;
                    end
                end
                S_EXIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_ad5791_cfg_seq.sv
// tb_axis_ad5791_cfg_seq
// Scoreboard bench: stimulus pushes expected config writes and expected
// done/skipped results; a monitor pops and compares on every send rise and
// every done pulse. A small serializer model answers the send handshake.
// Works with or without AD5791_CFG_SOFTRESET_EN defined.
module tb_axis_ad5791_cfg_seq;

    localparam int NUM_DAC        = 6;
    localparam int DW             = 24;
    localparam int TW             = 32;
    localparam int TIMEOUT_CYCLES = 4096;

    logic            a_clk = 1'b0;
    logic            a_resetn;
    logic            start;
    logic [DW-1:0]   ctrl_word;
    logic [NUM_DAC-1:0] axis_mask;
    logic            dac_ready;
    logic            configuration_mode;
    logic [2:0]      configuration_axis;
    logic            configuration_send;
    logic [TW-1:0]   M_AXISCFG_tdata;
    logic            M_AXISCFG_tvalid;
    logic            busy;
    logic            done;
    logic [NUM_DAC-1:0] skipped;

    axis_ad5791_cfg_seq #(
        .NUM_DAC(NUM_DAC), .DAC_WORD_WIDTH(DW),
        .SAXIS_TDATA_WIDTH(TW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .a_clk(a_clk), .a_resetn(a_resetn), .start(start), .ctrl_word(ctrl_word),
        .axis_mask(axis_mask), .dac_ready(dac_ready),
        .configuration_mode(configuration_mode), .configuration_axis(configuration_axis),
        .configuration_send(configuration_send), .M_AXISCFG_tdata(M_AXISCFG_tdata),
        .M_AXISCFG_tvalid(M_AXISCFG_tvalid), .busy(busy), .done(done), .skipped(skipped)
    );

    always #4 a_clk = ~a_clk;

    typedef struct {
        logic [2:0]    axis;
        logic [TW-1:0] data;
    } wr_t;

    wr_t                wr_q[$];
    logic [NUM_DAC-1:0] skip_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int mode_glitch = 0;
    int axis_bad    = 0;
    bit ser_en      = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_axis(input logic [2:0] ax, input logic [DW-1:0] w);
`ifdef AD5791_CFG_SOFTRESET_EN
        wr_q.push_back('{axis: ax, data: 32'h0040_0004});
`endif
        wr_q.push_back('{axis: ax, data: TW'(w)});
    endtask

    // First write of a run only (used when the run is aborted by reset).
    task automatic push_first(input logic [2:0] ax, input logic [DW-1:0] w);
`ifdef AD5791_CFG_SOFTRESET_EN
        wr_q.push_back('{axis: ax, data: 32'h0040_0004});
`else
        wr_q.push_back('{axis: ax, data: TW'(w)});
`endif
    endtask

    task automatic pulse_start(input logic [NUM_DAC-1:0] m, input logic [DW-1:0] w);
        axis_mask = m;
        ctrl_word = w;
        start     = 1'b1;
        @(negedge a_clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) @(negedge a_clk);
        check("done_within_budget", 32'(done_cnt != base), 32'd1);
    endtask

    // Serializer model: goes busy 3 cycles after a send request, idle 5 cycles later.
    initial begin
        logic prev;
        prev      = 1'b0;
        dac_ready = 1'b1;
        forever begin
            @(negedge a_clk);
            if (configuration_send && !prev && ser_en) begin
                repeat (3) @(negedge a_clk);
                dac_ready = 1'b0;
                repeat (5) @(negedge a_clk);
                dac_ready = 1'b1;
            end
            prev = configuration_send;
        end
    end

    // Monitor: compares every config write and every done pulse to the scoreboard.
    initial begin
        logic               prev;
        wr_t                w;
        logic [NUM_DAC-1:0] s;
        prev = 1'b0;
        forever begin
            @(negedge a_clk);
            if (configuration_send && !prev) begin
                check("write_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("write_axis", 32'(configuration_axis), 32'(w.axis));
                    check("write_tdata", M_AXISCFG_tdata, w.data);
                    check("write_tvalid", 32'(M_AXISCFG_tvalid), 32'd1);
                end
            end
            prev = configuration_send;
            if (done) begin
                done_cnt++;
                check("done_expected", 32'(skip_q.size() != 0), 32'd1);
                if (skip_q.size() != 0) begin
                    s = skip_q.pop_front();
                    check("done_skipped", 32'(skipped), 32'(s));
                    check("done_mode", 32'(configuration_mode), 32'd0);
                    check("done_busy", 32'(busy), 32'd0);
                end
            end
            if (busy !== configuration_mode) mode_glitch++;
            if (configuration_axis >= 3'(NUM_DAC)) axis_bad++;
        end
    end

    initial begin
        int cycles;
        a_resetn  = 1'b0;
        start     = 1'b0;
        ctrl_word = '0;
        axis_mask = '0;
        repeat (3) @(negedge a_clk);

        // Reset state
        check("rst_mode", 32'(configuration_mode), 32'd0);
        check("rst_send", 32'(configuration_send), 32'd0);
        check("rst_tvalid", 32'(M_AXISCFG_tvalid), 32'd0);
        check("rst_tdata", M_AXISCFG_tdata, 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_skipped", 32'(skipped), 32'd0);
        a_resetn = 1'b1;
        repeat (2) @(negedge a_clk);

        // Two axes, serializer answers normally
        push_axis(3'd0, 24'h200012);
        push_axis(3'd2, 24'h200012);
        skip_q.push_back(6'b000000);
        pulse_start(6'b000101, 24'h200012);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(1000);
        repeat (3) @(negedge a_clk);

        // Empty mask: done on the following cycle, no mode assertion
        skip_q.push_back(6'b000000);
        axis_mask = '0;
        ctrl_word = 24'h123456;
        start     = 1'b1;
        @(negedge a_clk);
        start     = 1'b0;
        check("empty_done_next_cycle", 32'(done), 32'd1);
        check("empty_mode", 32'(configuration_mode), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge a_clk);

        // Serializer never goes busy: timeout marks the axis skipped
        ser_en = 1'b0;
        push_axis(3'd0, 24'h0000A5);
        skip_q.push_back(6'b000001);
        pulse_start(6'b000001, 24'h0000A5);
        cycles = 0;
        begin
            int base;
            base = done_cnt;
            for (int i = 0; i < 12000 && done_cnt == base; i++) begin
                @(negedge a_clk);
                cycles++;
            end
            check("timeout_done_within_budget", 32'(done_cnt != base), 32'd1);
        end
        check("timeout_duration_min", 32'(cycles >= TIMEOUT_CYCLES), 32'd1);
        ser_en = 1'b1;
        @(negedge a_clk);
        check("timeout_mode_low", 32'(configuration_mode), 32'd0);
        repeat (3) @(negedge a_clk);

        // Start re-pulsed mid-run is ignored
        push_axis(3'd0, 24'h0ABCDE);
        push_axis(3'd1, 24'h0ABCDE);
        skip_q.push_back(6'b000000);
        pulse_start(6'b000011, 24'h0ABCDE);
        repeat (3) @(negedge a_clk);
        pulse_start(6'b000100, 24'h111111);
        wait_done(1500);
        repeat (40) @(negedge a_clk);
        check("repulse_no_extra_writes", 32'(wr_q.size()), 32'd0);
        check("repulse_single_done", 32'(skip_q.size()), 32'd0);

        // Reset while the serializer is busy (WAIT_HIGH): immediate clear, no done
        push_first(3'd0, 24'h0F0F0F);
        pulse_start(6'b000001, 24'h0F0F0F);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge a_clk);
                seen = !dac_ready;
            end
            check("reach_wait_high", 32'(seen), 32'd1);
        end
        @(negedge a_clk);
        #2 a_resetn = 1'b0;
        #1;
        check("abort_mode", 32'(configuration_mode), 32'd0);
        check("abort_send_tvalid", 32'({configuration_send, M_AXISCFG_tvalid}), 32'd0);
        check("abort_tdata", M_AXISCFG_tdata, 32'd0);
        check("abort_axis", 32'(configuration_axis), 32'd0);
        check("abort_busy_done", 32'({busy, done}), 32'd0);
        @(negedge a_clk);
        a_resetn = 1'b1;
        repeat (10) @(negedge a_clk);
        check("abort_no_pending_write", 32'(wr_q.size()), 32'd0);

        // Fresh run after reset (with soft-reset enabled: 0x400004 then ctrl_word)
        push_axis(3'd1, 24'h3C0F0F);
        skip_q.push_back(6'b000000);
        pulse_start(6'b000010, 24'h3C0F0F);
        wait_done(1000);
        repeat (20) @(negedge a_clk);

        check("all_writes_seen", 32'(wr_q.size()), 32'd0);
        check("all_dones_seen", 32'(skip_q.size()), 32'd0);
        check("mode_tracks_busy", 32'(mode_glitch), 32'd0);
        check("axis_in_range", 32'(axis_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
